// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises sclk/ncs/copi into the clk domain and produces one-cycle
// sclk rise/fall pulses from an extra history flop on sclk.
module spi_in_sync
    import spi_regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ncs,
    input  logic copi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ncs_s,
    output logic copi_s
);

    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES-1:0] ncs_q;
    logic [SYNC_STAGES-1:0] copi_q;

    // ncs resets deselected so a reset never looks like a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            ncs_q  <= '1;
            copi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
            ncs_q  <= {ncs_q[SYNC_STAGES-2:0], ncs};
            copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign ncs_s     = ncs_q[SYNC_STAGES-1];
    assign copi_s    = copi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register file.
// Define SPI_BURST_EN to enable auto-increment bursts within one frame.
module spi_regfile_periph
    import spi_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 5,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int unsigned CNT_W = $clog2(ADDR_W > DATA_W ? ADDR_W : DATA_W);

    logic sclk_rise, sclk_fall, ncs_s, copi_s;

    spi_in_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ncs_s     (ncs_s),
        .copi_s    (copi_s)
    );

    spi_state_t                 state;
    logic [CNT_W-1:0]           cnt;
    logic                       rw;
    logic [ADDR_W-1:0]          addr;
    logic [DATA_W-2:0]          data_sh;
    logic [DATA_W-1:0]          out_sh;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] word_next;

    assign addr_next = {addr[ADDR_W-2:0], copi_s};
    assign word_next = {data_sh, copi_s};
    assign regs_out  = regs_q;

    // Out-of-range addresses read as zero
    function automatic logic [DATA_W-1:0] reg_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (a == ADDR_W'(i))
                v = regs_q[i*DATA_W +: DATA_W];
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rw      <= RW_READ;
            addr    <= '0;
            data_sh <= '0;
            out_sh  <= '0;
            regs_q  <= RESET_VAL;
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (ncs_s) begin
                state   <= IDLE;
                cnt     <= '0;
                data_sh <= '0;
                out_sh  <= '0;
                cipo    <= 1'b0;
                cipo_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                        cnt   <= '0;
                    end
                    CMD: if (sclk_rise) begin
                        rw    <= copi_s;
                        state <= ADDR;
                        cnt   <= '0;
                    end
                    ADDR: if (sclk_rise) begin
                        addr <= addr_next;
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            state <= DATA;
                            cnt   <= '0;
                            if (rw == RW_READ) begin
                                out_sh  <= reg_read(addr_next);
                                cipo_oe <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sclk_fall && rw == RW_READ) begin
                            cipo   <= out_sh[DATA_W-1];
                            out_sh <= {out_sh[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            data_sh <= word_next[DATA_W-2:0];
                            if (cnt == CNT_W'(DATA_W - 1)) begin
                                cnt <= '0;
                                if (rw == RW_WRITE) begin
                                    for (int unsigned i = 0; i < NUM_REGS; i++)
                                        if (addr == ADDR_W'(i))
                                            regs_q[i*DATA_W +: DATA_W] <= word_next;
                                    wr_stb  <= 1'b1;
                                    wr_addr <= addr;
                                end
`ifdef SPI_BURST_EN
                                addr <= addr + 1'b1;
                                if (rw == RW_READ)
                                    out_sh <= reg_read(addr + 1'b1);
`else
                                state   <= DONE;
                                cipo    <= 1'b0;
                                cipo_oe <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
